// File: rtl/automat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | automat_pkg                                                          |
// | Shared state encoding, coin values and coin priority selection for   |
// | the parametrised bottle vending machine.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package automat_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam logic [3:0] COIN1  = 4'd1;
    localparam logic [3:0] COIN5  = 4'd5;
    localparam logic [3:0] COIN10 = 4'd10;

    // Only the highest-valued simultaneous pulse counts; the rest are dropped.
    function automatic logic [3:0] coin_value(input logic lei10,
                                              input logic lei5,
                                              input logic leu1);
        logic [3:0] v;
        v = 4'd0;
        if (lei10)     v = COIN10;
        else if (lei5) v = COIN5;
        else if (leu1) v = COIN1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/automat_change_disp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | automat_change_disp                                                  |
// | Change register and payout decode: 5-lei coins first, then 1-leu.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module automat_change_disp
    import automat_pkg::*;
#(
    parameter int CREDIT_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_val,
    input  logic                active,
    output logic                done,
    output logic                pending,
    output logic                rest1,
    output logic                rest5
);

    localparam logic [CREDIT_W-1:0] FIVE = CREDIT_W'(COIN5);
    localparam logic [CREDIT_W-1:0] ONE  = CREDIT_W'(COIN1);

    logic [CREDIT_W-1:0] change_q;
    logic [CREDIT_W-1:0] change_d;

    always_comb begin
        change_d = change_q;
        if (load) begin
            change_d = load_val;
        end else if (active) begin
            if (change_q >= FIVE)        change_d = change_q - FIVE;
            else if (change_q != '0)     change_d = change_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) change_q <= '0;
        else       change_q <= change_d;
    end

    // The payout this cycle empties the register when it holds exactly 5 or 1.
    assign done    = active && ((change_q == FIVE) || (change_q <= ONE));
    assign pending = (change_q != '0);
    assign rest5   = active && (change_q >= FIVE);
    assign rest1   = active && (change_q != '0) && (change_q < FIVE);

endmodule
`default_nettype wire

// File: rtl/automat_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | automat_param                                                        |
// | Parametrised bottle vending FSM with credit, change and sales count. |
// | Optional refund on cancel: define AUTOMAT_CANCEL_EN.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module automat_param
    import automat_pkg::*;
#(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 5,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                LEU1,
    input  logic                LEI5,
    input  logic                LEI10,
    input  logic                cancel,
    output logic                ELIBSTICLA,
    output logic                REST1,
    output logic                REST5,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [CNT_W-1:0]    sold_cnt
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]    sold_cnt_q, sold_cnt_d;
    logic                load;
    logic [CREDIT_W-1:0] load_val;
    logic                done;
    logic                pending;
    logic                cancel_req;
    logic [3:0]          coin_v;
    logic [CREDIT_W-1:0] sum;

`ifdef AUTOMAT_CANCEL_EN
    assign cancel_req = cancel;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_req    = 1'b0;
`endif

    assign coin_v = coin_value(LEI10, LEI5, LEU1);
    assign sum    = credit_q + CREDIT_W'(coin_v);

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        sold_cnt_d = sold_cnt_q;
        load       = 1'b0;
        load_val   = '0;
        case (state_q)
            COLLECT: begin
                if ((coin_v != 4'd0) && (sum >= PRICE_C)) begin
                    load     = 1'b1;
                    load_val = sum - PRICE_C;
                    credit_d = '0;
                    state_d  = VEND;
                end else if (cancel_req && (sum != '0)) begin
                    // Refund includes any coin arriving alongside the cancel.
                    load     = 1'b1;
                    load_val = sum;
                    credit_d = '0;
                    state_d  = CHANGE;
                end else begin
                    credit_d = sum;
                end
            end
            VEND: begin
                sold_cnt_d = sold_cnt_q + CNT_W'(1);
                state_d    = pending ? CHANGE : COLLECT;
            end
            CHANGE: begin
                if (done) state_d = COLLECT;
            end
            default: begin
                state_d  = COLLECT;
                credit_d = '0;
                load     = 1'b1;
                load_val = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= COLLECT;
            credit_q   <= '0;
            sold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            sold_cnt_q <= sold_cnt_d;
        end
    end

    automat_change_disp #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .active   (state_q == CHANGE),
        .done     (done),
        .pending  (pending),
        .rest1    (REST1),
        .rest5    (REST5)
    );

    assign ELIBSTICLA = (state_q == VEND);
    assign busy       = (state_q != COLLECT);
    assign credit     = credit_q;
    assign sold_cnt   = sold_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_automat_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_automat_param                                                     |
// | Scoreboard bench: stimulus queues expected strobes, monitor checks.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_automat_param;

    localparam int PRICE    = 3;
    localparam int CREDIT_W = 5;
    localparam int CNT_W    = 2;

    localparam int EV_VEND = 1;
    localparam int EV_R1   = 2;
    localparam int EV_R5   = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                LEU1 = 1'b0;
    logic                LEI5 = 1'b0;
    logic                LEI10 = 1'b0;
    logic                cancel = 1'b0;
    logic                ELIBSTICLA;
    logic                REST1;
    logic                REST5;
    logic                busy;
    logic [CREDIT_W-1:0] credit;
    logic [CNT_W-1:0]    sold_cnt;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    automat_param #(
        .PRICE    (PRICE),
        .CREDIT_W (CREDIT_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .LEU1       (LEU1),
        .LEI5       (LEI5),
        .LEI10      (LEI10),
        .cancel     (cancel),
        .ELIBSTICLA (ELIBSTICLA),
        .REST1      (REST1),
        .REST5      (REST5),
        .busy       (busy),
        .credit     (credit),
        .sold_cnt   (sold_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        q.push_back(e);
    endtask

    // Drive one set of pulses for a single edge; e is the edge count after it.
    task automatic coin(input logic l10, input logic l5, input logic l1,
                        input logic cx, output int e);
        LEI10  = l10;
        LEI5   = l5;
        LEU1   = l1;
        cancel = cx;
        @(posedge clk);
        #1;
        e      = cyc;
        LEI10  = 1'b0;
        LEI5   = 1'b0;
        LEU1   = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ELIBSTICLA || REST1 || REST5) begin
            int   kind;
            ev_t  e;
            kind = ELIBSTICLA ? EV_VEND : (REST5 ? EV_R5 : EV_R1);
            checks++;
            if (int'(ELIBSTICLA) + int'(REST1) + int'(REST5) != 1) begin
                errors++;
                $display("FAIL strobe_onehot: got E=%0b R1=%0b R5=%0b expected one-hot (cycle %0d)",
                         ELIBSTICLA, REST1, REST5, cyc);
            end else if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got kind %0d expected none (cycle %0d)", kind, cyc);
            end else begin
                e = q.pop_front();
                if (e.kind != kind || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL strobe: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                             kind, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int e2;

        idle(2);
        check("rst_elib",   int'(ELIBSTICLA), 0);
        check("rst_rest1",  int'(REST1), 0);
        check("rst_rest5",  int'(REST5), 0);
        check("rst_busy",   int'(busy), 0);
        check("rst_credit", int'(credit), 0);
        check("rst_sold",   int'(sold_cnt), 0);
        reset = 1'b0;
        idle(1);

        // Three 1-leu coins: exact price, no change.
        coin(0, 0, 1, 0, e);
        check("t1_credit1", int'(credit), 1);
        coin(0, 0, 1, 0, e);
        check("t1_credit2", int'(credit), 2);
        coin(0, 0, 1, 0, e);
        expect_ev(EV_VEND, e);
        check("t1_busy_vend", int'(busy), 1);
        check("t1_credit0", int'(credit), 0);
        idle(1);
        check("t1_busy_done", int'(busy), 0);
        check("t1_sold", int'(sold_cnt), 1);

        // 10 lei: change 7 = one 5 then two 1s.
        coin(1, 0, 0, 0, e);
        expect_ev(EV_VEND, e);
        expect_ev(EV_R5, e + 1);
        expect_ev(EV_R1, e + 2);
        expect_ev(EV_R1, e + 3);
        idle(3);
        check("t2_busy_last", int'(busy), 1);
        idle(1);
        check("t2_busy_done", int'(busy), 0);
        check("t2_sold", int'(sold_cnt), 2);

        // 5 and 1 together: only 5 counts, change 2.
        coin(0, 1, 1, 0, e);
        expect_ev(EV_VEND, e);
        expect_ev(EV_R1, e + 1);
        expect_ev(EV_R1, e + 2);
        idle(3);
        check("t3_busy_done", int'(busy), 0);
        check("t3_credit", int'(credit), 0);
        check("t3_sold", int'(sold_cnt), 3);

        // Coin during VEND is ignored; fourth vend wraps the 2-bit counter.
        coin(0, 0, 1, 0, e);
        coin(0, 0, 1, 0, e);
        coin(0, 0, 1, 0, e);
        expect_ev(EV_VEND, e);
        coin(0, 1, 0, 0, e2);
        check("t4_busy", int'(busy), 0);
        check("t4_credit", int'(credit), 0);
        check("t4_sold_wrap", int'(sold_cnt), 0);

        // 1 then 10: change 8 = 5 + 1 + 1 + 1.
        coin(0, 0, 1, 0, e);
        coin(1, 0, 0, 0, e);
        expect_ev(EV_VEND, e);
        expect_ev(EV_R5, e + 1);
        expect_ev(EV_R1, e + 2);
        expect_ev(EV_R1, e + 3);
        expect_ev(EV_R1, e + 4);
        idle(5);
        check("t6_busy_done", int'(busy), 0);
        check("t6_sold", int'(sold_cnt), 1);

        // Cancel with credit 2.
        coin(0, 0, 1, 0, e);
        coin(0, 0, 1, 0, e);
        coin(0, 0, 0, 1, e);
`ifdef AUTOMAT_CANCEL_EN
        expect_ev(EV_R1, e);
        expect_ev(EV_R1, e + 1);
        check("t5_busy", int'(busy), 1);
        check("t5_credit", int'(credit), 0);
        idle(2);
        check("t5_busy_done", int'(busy), 0);
        check("t5_sold", int'(sold_cnt), 1);
`else
        check("t5_credit_kept", int'(credit), 2);
        check("t5_busy", int'(busy), 0);
        coin(0, 0, 1, 0, e);
        expect_ev(EV_VEND, e);
        idle(1);
        check("t5_sold", int'(sold_cnt), 2);
`endif

        // Reset in the middle of the change payout.
        coin(1, 0, 0, 0, e);
        expect_ev(EV_VEND, e);
        expect_ev(EV_R5, e + 1);
        idle(1);
        reset = 1'b1;
        idle(1);
        check("t7_elib",   int'(ELIBSTICLA), 0);
        check("t7_rest1",  int'(REST1), 0);
        check("t7_rest5",  int'(REST5), 0);
        check("t7_busy",   int'(busy), 0);
        check("t7_credit", int'(credit), 0);
        check("t7_sold",   int'(sold_cnt), 0);
        reset = 1'b0;
        idle(3);

        check("scoreboard_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
